mips_hazard_ctrl: RTL and testbench
===================================

Name: mips_hazard_ctrl

Overview:
Hazard and pipeline-control block for the next-generation 5-stage MIPS pipeline. It adds what the current datapath lacks: EX-stage operand forwarding, load-use stall with parametrised memory latency, and branch/jump flush steering. It also maintains saturating performance counters. It sits beside the stage buffers, driving the PC enable, the IF/ID enable, the per-buffer flushes and the ALU operand-select muxes.

Parameters:
REG_ADDR_W, 5, register-specifier width
LOAD_STALL, 1, bubbles inserted per load-use hazard (1..15; >1 for multi-cycle data memory)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
id_rs, id_rt  in  REG_ADDR_W  source specifiers of the instruction in ID
id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs/rt
ex_rs, ex_rt  in  REG_ADDR_W  source specifiers held in ID/EX
ex_mem_read  in  1  instruction in EX is a load
ex_write_reg  in  REG_ADDR_W  destination of the EX instruction
mem_reg_write, wb_reg_write  in  1  RegWrite in EX/MEM and MEM/WB
mem_write_reg, wb_write_reg  in  REG_ADDR_W  destinations in EX/MEM and MEM/WB
branch_taken  in  1  Branch & Zero resolved in MEM
jump_id  in  1  J decoded in ID
wb_valid  in  1  a non-bubble instruction retires this cycle
cnt_clear  in  1  synchronous clear of all counters
pc_enable  out  1  PC register load enable
if_id_enable  out  1  IF/ID load enable
if_id_flush, id_ex_flush, ex_mem_flush  out  1  bubble insertion into each buffer
fwd_a, fwd_b  out  2  ALU operand select: 00 register file, 01 WB value, 10 MEM ALU result
cycle_cnt, stall_cnt, flush_cnt, retire_cnt  out  CNT_W  performance counters

Behaviour:
- Clock is clk; reset is synchronous and active-high. While reset is high: FSM goes to RUN, stall counter goes to 0, all counters go to 0. Outputs are forced to pc_enable=1, if_id_enable=1, all flushes=0, fwd_a=fwd_b=00.
- Forwarding is combinational, zero latency.
  - fwd_a=10 if mem_reg_write && mem_write_reg!=0 && mem_write_reg==ex_rs.
  - Else fwd_a=01 if wb_reg_write && wb_write_reg!=0 && wb_write_reg==ex_rs.
  - Else fwd_a=00.
  - fwd_b: same rules against ex_rt.
  - MEM has priority over WB. Register 0 never forwards.
- Load-use hazard (lu) = ex_mem_read && ex_write_reg!=0 && ((id_uses_rs && ex_write_reg==id_rs) || (id_uses_rt && ex_write_reg==id_rt)).
- FSM states are RUN and STALL. The internal counter scnt is 4 bits wide.
  - RUN, lu=1, branch_taken=0: assert stall this cycle. If LOAD_STALL>1, go to STALL with scnt=LOAD_STALL-1; else stay in RUN.
  - STALL: assert stall each cycle and decrement scnt. When scnt reaches 1, return to RUN on the next edge.
  - Total stall length is exactly LOAD_STALL cycles per hazard.
- Stall outputs: pc_enable=0, if_id_enable=0, id_ex_flush=1.
- branch_taken (highest priority):
  - Outputs: pc_enable=1, if_id_enable=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - Overrides any stall. FSM goes to RUN and scnt=0 on the next edge.
- jump_id with no stall and no branch_taken: if_id_flush=1 only. If a stall is active, the stall wins and the jump is re-evaluated once the stall ends.
- No hazard: pc_enable=1, if_id_enable=1, all flushes 0.
- Counters, all saturating at 2^CNT_W-1 and never wrapping:
  - cycle_cnt +1 every non-reset cycle.
  - stall_cnt +1 each cycle pc_enable=0.
  - flush_cnt +1 each cycle with branch_taken, or jump_id accepted.
  - retire_cnt +1 when wb_valid.
- cnt_clear: every counter reads 0 next cycle. Clear beats a same-cycle increment.
- Reset mid-STALL: RUN next cycle; no residual stall.

Test Plan:
- Forward priority: ex_rs=3, mem_write_reg=3, mem_reg_write=1, wb_write_reg=3, wb_reg_write=1 -> fwd_a=10. Drop mem_reg_write -> fwd_a=01. With ex_rs=0 and matching writes -> fwd_a=00.
- Load-use, LOAD_STALL=1: ex_mem_read=1, ex_write_reg=8, id_rs=8, id_uses_rs=1 -> exactly 1 cycle of pc_enable=0, if_id_enable=0, id_ex_flush=1. stall_cnt=1.
- Load-use, LOAD_STALL=3: same stimulus held 1 cycle -> pc_enable=0 for exactly 3 consecutive cycles, then 1. stall_cnt=3.
- Branch during stall (LOAD_STALL=3): assert branch_taken in the 2nd stall cycle -> that cycle pc_enable=1 with all three flushes=1. Next cycle: RUN, no stall. flush_cnt=1.
- Jump vs stall: jump_id=1 with lu=1 -> if_id_flush=0 and stall asserted. Next cycle with lu=0 -> if_id_flush=1.
- Counters: CNT_W=4, run 20 cycles -> cycle_cnt=15 (saturated). Pulse cnt_clear with wb_valid=1 -> retire_cnt=0 next cycle. Reset asserted in STALL -> STALL exited, all counters 0.

Source files
------------

// File: rtl/mips_hazard_ctrl.sv
// Hazard control for the 5-stage MIPS pipeline: EX forwarding, load-use
// stall with configurable length, branch/jump flush steering, perf counters.
module mips_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic                  branch_taken,
    input  logic                  jump_id,
    input  logic                  wb_valid,
    input  logic                  cnt_clear,
    output logic                  pc_enable,
    output logic                  if_id_enable,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    localparam logic [3:0] SCNT_INIT = 4'(LOAD_STALL - 1);
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    state_t     state, state_n;
    logic [3:0] scnt, scnt_n;

    logic lu;
    logic stall;
    logic jump_acc;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src
    );
        if (mem_reg_write && mem_write_reg != ZERO_REG &&
            mem_write_reg == src)
            return 2'b10;
        else if (wb_reg_write && wb_write_reg != ZERO_REG &&
                 wb_write_reg == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        if (en && v != {CNT_W{1'b1}})
            return v + CNT_W'(1);
        else
            return v;
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!reset) begin
            fwd_a = fwd_sel(ex_rs);
            fwd_b = fwd_sel(ex_rt);
        end
    end

    always_comb begin
        lu = ex_mem_read && ex_write_reg != ZERO_REG &&
             ((id_uses_rs && ex_write_reg == id_rs) ||
              (id_uses_rt && ex_write_reg == id_rt));
    end

    // A pending multi-cycle stall holds regardless of the current ID contents
    always_comb begin
        stall    = !reset && !branch_taken &&
                   (state == STALL || lu);
        jump_acc = !reset && !branch_taken && !stall && jump_id;
    end

    always_comb begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset) begin
            pc_enable = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (stall) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
        end else if (jump_id) begin
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        if (branch_taken) begin
            state_n = RUN;
            scnt_n  = 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (lu && LOAD_STALL > 1) begin
                        state_n = STALL;
                        scnt_n  = SCNT_INIT;
                    end
                end
                STALL: begin
                    if (scnt <= 4'd1) begin
                        state_n = RUN;
                        scnt_n  = 4'd0;
                    end else begin
                        scnt_n = scnt - 4'd1;
                    end
                end
                default: begin
                    state_n = RUN;
                    scnt_n  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            scnt  <= 4'd0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
            stall_cnt  <= sat_inc(stall_cnt, !pc_enable);
            flush_cnt  <= sat_inc(flush_cnt, branch_taken || jump_acc);
            retire_cnt <= sat_inc(retire_cnt, wb_valid);
        end
    end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl: three instances cover
// LOAD_STALL=1, LOAD_STALL=3 and a 4-bit counter build.
module tb_mips_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg;
    logic [4:0] mem_write_reg, wb_write_reg;
    logic       id_uses_rs, id_uses_rt, ex_mem_read;
    logic       mem_reg_write, wb_reg_write;
    logic       branch_taken, jump_id, wb_valid, cnt_clear;

    logic        a_pc, a_ifid, a_fif, a_fid, a_fex;
    logic [1:0]  a_fa, a_fb;
    logic [31:0] a_cyc, a_stl, a_fl, a_ret;

    logic        b_pc, b_ifid, b_fif, b_fid, b_fex;
    logic [1:0]  b_fa, b_fb;
    logic [31:0] b_cyc, b_stl, b_fl, b_ret;

    logic        c_pc, c_ifid, c_fif, c_fid, c_fex;
    logic [1:0]  c_fa, c_fb;
    logic [3:0]  c_cyc, c_stl, c_fl, c_ret;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(32)) u_ls1 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_write_reg(mem_write_reg), .wb_write_reg(wb_write_reg),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .wb_valid(wb_valid), .cnt_clear(cnt_clear),
        .pc_enable(a_pc), .if_id_enable(a_ifid),
        .if_id_flush(a_fif), .id_ex_flush(a_fid),
        .ex_mem_flush(a_fex), .fwd_a(a_fa), .fwd_b(a_fb),
        .cycle_cnt(a_cyc), .stall_cnt(a_stl),
        .flush_cnt(a_fl), .retire_cnt(a_ret)
    );

    mips_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(32)) u_ls3 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_write_reg(mem_write_reg), .wb_write_reg(wb_write_reg),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .wb_valid(wb_valid), .cnt_clear(cnt_clear),
        .pc_enable(b_pc), .if_id_enable(b_ifid),
        .if_id_flush(b_fif), .id_ex_flush(b_fid),
        .ex_mem_flush(b_fex), .fwd_a(b_fa), .fwd_b(b_fb),
        .cycle_cnt(b_cyc), .stall_cnt(b_stl),
        .flush_cnt(b_fl), .retire_cnt(b_ret)
    );

    mips_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(4)) u_c4 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_write_reg(mem_write_reg), .wb_write_reg(wb_write_reg),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .wb_valid(wb_valid), .cnt_clear(cnt_clear),
        .pc_enable(c_pc), .if_id_enable(c_ifid),
        .if_id_flush(c_fif), .id_ex_flush(c_fid),
        .ex_mem_flush(c_fex), .fwd_a(c_fa), .fwd_b(c_fb),
        .cycle_cnt(c_cyc), .stall_cnt(c_stl),
        .flush_cnt(c_fl), .retire_cnt(c_ret)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic on);
        ex_mem_read  = on;
        ex_write_reg = on ? 5'd8 : 5'd0;
        id_rs        = on ? 5'd8 : 5'd0;
        id_uses_rs   = on;
    endtask

    initial begin
        reset = 1'b1;
        {id_rs, id_rt, ex_rs, ex_rt, ex_write_reg} = '0;
        {mem_write_reg, wb_write_reg} = '0;
        {id_uses_rs, id_uses_rt, ex_mem_read} = '0;
        {mem_reg_write, wb_reg_write} = '0;
        {branch_taken, jump_id, wb_valid, cnt_clear} = '0;

        set_lu(1'b1);
        ex_rs = 5'd3; mem_write_reg = 5'd3; mem_reg_write = 1'b1;
        tick();
        tick();
        chk("rst_pc", {31'd0, a_pc}, 32'd1);
        chk("rst_ifid", {31'd0, a_ifid}, 32'd1);
        chk("rst_idex_fl", {31'd0, a_fid}, 32'd0);
        chk("rst_fwd_a", {30'd0, a_fa}, 32'd0);
        chk("rst_cyc", a_cyc, 32'd0);
        chk("rst_stl", b_stl, 32'd0);
        set_lu(1'b0);
        mem_reg_write = 1'b0;
        reset = 1'b0;

        ex_rs = 5'd3;
        mem_write_reg = 5'd3; mem_reg_write = 1'b1;
        wb_write_reg = 5'd3;  wb_reg_write = 1'b1;
        #1 chk("fwd_mem_pri", {30'd0, a_fa}, 32'd2);
        mem_reg_write = 1'b0;
        #1 chk("fwd_wb", {30'd0, a_fa}, 32'd1);
        ex_rs = 5'd0; mem_write_reg = 5'd0; wb_write_reg = 5'd0;
        mem_reg_write = 1'b1;
        #1 chk("fwd_r0", {30'd0, a_fa}, 32'd0);
        ex_rt = 5'd5; wb_write_reg = 5'd5;
        #1 chk("fwd_b_wb", {30'd0, a_fb}, 32'd1);
        ex_rt = 5'd0; wb_write_reg = 5'd0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        tick();
        set_lu(1'b1);
        #1;
        chk("lu1_pc", {31'd0, a_pc}, 32'd0);
        chk("lu1_ifid", {31'd0, a_ifid}, 32'd0);
        chk("lu1_idex_fl", {31'd0, a_fid}, 32'd1);
        chk("lu3_pc_c1", {31'd0, b_pc}, 32'd0);
        tick();
        set_lu(1'b0);
        #1;
        chk("lu1_pc_after", {31'd0, a_pc}, 32'd1);
        chk("lu1_stl", a_stl, 32'd1);
        chk("lu3_pc_c2", {31'd0, b_pc}, 32'd0);
        tick();
        chk("lu3_pc_c3", {31'd0, b_pc}, 32'd0);
        tick();
        chk("lu3_pc_done", {31'd0, b_pc}, 32'd1);
        chk("lu3_stl", b_stl, 32'd3);

        set_lu(1'b1);
        tick();
        set_lu(1'b0);
        branch_taken = 1'b1;
        #1;
        chk("br_pc", {31'd0, b_pc}, 32'd1);
        chk("br_ifid", {31'd0, b_ifid}, 32'd1);
        chk("br_fl", {29'd0, b_fif, b_fid, b_fex}, 32'd7);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("br_run_pc", {31'd0, b_pc}, 32'd1);
        chk("br_flcnt", b_fl, 32'd1);
        chk("br_stl", b_stl, 32'd4);

        set_lu(1'b1);
        jump_id = 1'b1;
        #1;
        chk("jmp_stall_fl", {31'd0, a_fif}, 32'd0);
        chk("jmp_stall_pc", {31'd0, a_pc}, 32'd0);
        tick();
        set_lu(1'b0);
        #1;
        chk("jmp_acc_fl", {31'd0, a_fif}, 32'd1);
        chk("jmp_ls3_held", {31'd0, b_fif}, 32'd0);
        tick();
        jump_id = 1'b0;
        chk("jmp_flcnt", a_fl, 32'd2);

        repeat (20) tick();
        chk("c4_sat", {28'd0, c_cyc}, 32'd15);

        cnt_clear = 1'b1; wb_valid = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("clr_ret", {28'd0, c_ret}, 32'd0);
        chk("clr_cyc", {28'd0, c_cyc}, 32'd0);
        repeat (3) tick();
        wb_valid = 1'b0;
        chk("ret_cnt", {28'd0, c_ret}, 32'd3);
        chk("cyc_after_clr", {28'd0, c_cyc}, 32'd3);

        set_lu(1'b1);
        tick();
        set_lu(1'b0);
        reset = 1'b1;
        #1 chk("rst_in_stall_pc", {31'd0, b_pc}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_pc", {31'd0, b_pc}, 32'd1);
        chk("post_rst_stl", b_stl, 32'd0);
        chk("post_rst_cyc", b_cyc, 32'd0);
        tick();
        chk("post_rst_pc2", {31'd0, b_pc}, 32'd1);
        chk("post_rst_stl2", b_stl, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
